// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 8-bit ALU and the 16-bit sequencer.
//   - alu_8 opcode constants (5-bit opcode field)
//   - op16_t : 16-bit operation requested by the execute stage
//   - seq_state_t : sequencer FSM states
//   - carry_of : carry/borrow recovery for one byte pass, since alu_8
//     has no carry output
package alu_pkg;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_CMP = 5'd5;
    localparam logic [4:0] ALU_SLL = 5'd6;
    localparam logic [4:0] ALU_SRL = 5'd7;
    localparam logic [4:0] ALU_SLA = 5'd8;
    localparam logic [4:0] ALU_SRA = 5'd9;
    localparam logic [4:0] ALU_ROL = 5'd10;
    localparam logic [4:0] ALU_ROR = 5'd11;
    localparam logic [4:0] ALU_INC = 5'd12;
    localparam logic [4:0] ALU_DEC = 5'd13;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'd0,
        OP_SUB16 = 2'd1,
        OP_INC16 = 2'd2,
        OP_DEC16 = 2'd3
    } op16_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_CIN  = 3'd2,
        ST_HI   = 3'd3,
        ST_FIX  = 3'd4,
        ST_DONE = 3'd5
    } seq_state_t;

    // A modular add wrapped iff the sum is below an operand; a subtract
    // borrowed iff the minuend is below the subtrahend.
    function automatic logic carry_of(input logic       is_sub,
                                      input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic [7:0] res);
        return is_sub ? (a < b) : (res < a);
    endfunction

endpackage

// File: rtl/alu_8.sv
// alu_8: shared combinational 8-bit ALU (no carry out).
// Ports:
//   a, b    : 8-bit operands
//   opcode  : 5-bit operation select (see alu_pkg); unused codes give 0
//   out     : 8-bit result
module alu_8
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [4:0] opcode,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        case (opcode)
            ALU_ADD: out = a + b;
            ALU_SUB: out = a - b;
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_XOR: out = a ^ b;
            ALU_CMP: out = a - b;
            ALU_SLL: out = {a[6:0], 1'b0};
            ALU_SRL: out = {1'b0, a[7:1]};
            ALU_SLA: out = {a[6:0], 1'b0};
            ALU_SRA: out = {a[7], a[7:1]};
            ALU_ROL: out = {a[6:0], a[7]};
            ALU_ROR: out = {a[0], a[7:1]};
            ALU_INC: out = a + 8'd1;
            ALU_DEC: out = a - 8'd1;
            default: out = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu16_sequencer.sv
// alu16_sequencer: runs 16-bit ADD/SUB/INC/DEC as byte passes on alu_8.
// Passes: low byte, (optional carry-in), high byte, high-byte carry fix-up.
// Carry is recovered from operand/result comparison.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   req_valid/ready   : request handshake (ready only when IDLE)
//   req_op            : 0=ADD16 1=SUB16 2=INC16 3=DEC16
//   req_a, req_b      : operands (req_b ignored for INC/DEC)
//   req_cin           : carry-in for ADD16/SUB16 (ALU16_SEQ_CARRY_IN_EN only)
//   rsp_valid/ready   : response handshake
//   rsp_result, rsp_c, rsp_z, rsp_s : result and flags, zero unless DONE
//   alu_a, alu_b, alu_opcode, alu_out : connection to alu_8
//
// Parameter FIXED_LATENCY=1 forces the optional states to always be visited.
// Optional macro: ALU16_SEQ_CARRY_IN_EN adds req_cin and the CIN state.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, ALU inputs parked at 0
// LO    | low byte pass, capture res_lo and low carry cl
// CIN   | apply carry-in to res_lo (macro build only)
// HI    | high byte pass, capture res_hi and high carry ch
// FIX   | propagate cl into res_hi via INC/DEC, fold overflow into ch
// DONE  | result presented, held until rsp_ready
module alu16_sequencer
    import alu_pkg::*;
#(
    parameter bit FIXED_LATENCY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
`ifdef ALU16_SEQ_CARRY_IN_EN
    input  logic        req_cin,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_c,
    output logic        rsp_z,
    output logic        rsp_s,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [7:0]  alu_out
);

    seq_state_t  state, state_nxt;
    logic        is_sub;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [7:0]  res_lo;
    logic [7:0]  res_hi;
    logic        cl;
    logic        ch;
`ifdef ALU16_SEQ_CARRY_IN_EN
    logic        cin_q;
`endif

    logic req_is_sub;
    logic req_is_unary;
    logic done;

    assign req_is_sub   = (op16_t'(req_op) == OP_SUB16) || (op16_t'(req_op) == OP_DEC16);
    assign req_is_unary = (op16_t'(req_op) == OP_INC16) || (op16_t'(req_op) == OP_DEC16);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            is_sub <= 1'b0;
            a_q    <= 16'h0000;
            b_q    <= 16'h0000;
            res_lo <= 8'h00;
            res_hi <= 8'h00;
            cl     <= 1'b0;
            ch     <= 1'b0;
`ifdef ALU16_SEQ_CARRY_IN_EN
            cin_q  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_sub <= req_is_sub;
                        a_q    <= req_a;
                        b_q    <= req_is_unary ? 16'h0001 : req_b;
`ifdef ALU16_SEQ_CARRY_IN_EN
                        cin_q  <= req_is_unary ? 1'b0 : req_cin;
`endif
                    end
                end
                ST_LO: begin
                    res_lo <= alu_out;
                    cl     <= carry_of(is_sub, a_q[7:0], b_q[7:0], alu_out);
                end
`ifdef ALU16_SEQ_CARRY_IN_EN
                ST_CIN: begin
                    if (cin_q) begin
                        res_lo <= alu_out;
                        cl     <= cl | (is_sub ? (res_lo == 8'h00) : (res_lo == 8'hFF));
                    end
                end
`endif
                ST_HI: begin
                    res_hi <= alu_out;
                    ch     <= carry_of(is_sub, a_q[15:8], b_q[15:8], alu_out);
                end
                ST_FIX: begin
                    // Without a low carry the fix-up pass is only a latency filler.
                    if (cl) begin
                        res_hi <= alu_out;
                        ch     <= ch | (is_sub ? (res_hi == 8'h00) : (res_hi == 8'hFF));
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_opcode = ALU_ADD;
        case (state)
            ST_IDLE: begin
                if (req_valid) state_nxt = ST_LO;
            end
            ST_LO: begin
                alu_a      = a_q[7:0];
                alu_b      = b_q[7:0];
                alu_opcode = is_sub ? ALU_SUB : ALU_ADD;
`ifdef ALU16_SEQ_CARRY_IN_EN
                state_nxt  = (cin_q || FIXED_LATENCY) ? ST_CIN : ST_HI;
`else
                state_nxt  = ST_HI;
`endif
            end
`ifdef ALU16_SEQ_CARRY_IN_EN
            ST_CIN: begin
                alu_a      = res_lo;
                alu_opcode = is_sub ? ALU_DEC : ALU_INC;
                state_nxt  = ST_HI;
            end
`endif
            ST_HI: begin
                alu_a      = a_q[15:8];
                alu_b      = b_q[15:8];
                alu_opcode = is_sub ? ALU_SUB : ALU_ADD;
                state_nxt  = (cl || FIXED_LATENCY) ? ST_FIX : ST_DONE;
            end
            ST_FIX: begin
                alu_a      = res_hi;
                alu_opcode = is_sub ? ALU_DEC : ALU_INC;
                state_nxt  = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign req_ready  = (state == ST_IDLE);
    assign done       = (state == ST_DONE);
    assign rsp_valid  = done;
    // Result registers are only exposed while DONE so stale data never leaks.
    assign rsp_result = done ? {res_hi, res_lo} : 16'h0000;
    assign rsp_c      = done & ch;
    assign rsp_z      = done & ({res_hi, res_lo} == 16'h0000);
    assign rsp_s      = done & res_hi[7];

endmodule
